// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - raster timing bundle between the generator and its consumers.
// frameCount exists only when FRAME_COUNTER_EN is defined.
interface video_timing_gen_if #(
  parameter int H_WIDTH = 11,
  parameter int V_WIDTH = 10
);
  logic               pixEn;
  logic               hsync;
  logic               vsync;
  logic               videoActive;
  logic               lineStarting;
  logic               lineEnding;
  logic               frameStart;
  logic [H_WIDTH-1:0] hPos;
  logic [V_WIDTH-1:0] vPos;
  logic               nextFrameActive;
  logic [V_WIDTH-1:0] nextVPos;
`ifdef FRAME_COUNTER_EN
  logic [15:0]        frameCount;
`endif

  modport master (
    input  pixEn,
    output hsync, vsync, videoActive, lineStarting, lineEnding, frameStart,
    output hPos, vPos, nextFrameActive, nextVPos
`ifdef FRAME_COUNTER_EN
    , output frameCount
`endif
  );

  modport slave (
    output pixEn,
    input  hsync, vsync, videoActive, lineStarting, lineEnding, frameStart,
    input  hPos, vPos, nextFrameActive, nextVPos
`ifdef FRAME_COUNTER_EN
    , input frameCount
`endif
  );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised raster timing generator with pixel enable and look-ahead strobes.
// Define FRAME_COUNTER_EN to add a 16-bit frameCount output.
module video_timing_gen #(
  parameter int   H_VISIBLE      = 800,
  parameter int   H_FRONT        = 40,
  parameter int   H_SYNC         = 128,
  parameter int   H_BACK         = 88,
  parameter int   V_VISIBLE      = 600,
  parameter int   V_FRONT        = 1,
  parameter int   V_SYNC         = 4,
  parameter int   V_BACK         = 23,
  parameter int   H_WIDTH        = 11,
  parameter int   V_WIDTH        = 10,
  parameter logic HSYNC_POL      = 1'b1,
  parameter logic VSYNC_POL      = 1'b1,
  parameter int   PIPELINE_DELAY = 0
) (
  input  logic                clk40,
  input  logic                reset,
  video_timing_gen_if.master  vid
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [H_WIDTH-1:0] H_LAST     = H_WIDTH'(H_TOTAL - 1);
  localparam logic [H_WIDTH-1:0] H_VIS      = H_WIDTH'(H_VISIBLE);
  localparam logic [H_WIDTH-1:0] H_VIS_LAST = H_WIDTH'(H_VISIBLE - 1);
  localparam logic [H_WIDTH-1:0] LS_AT      = H_WIDTH'(H_TOTAL - 1 - PIPELINE_DELAY);
  localparam logic [H_WIDTH-1:0] LE_AT      = H_WIDTH'(H_VISIBLE - 1 - PIPELINE_DELAY);
  localparam logic [V_WIDTH-1:0] V_LAST     = V_WIDTH'(V_TOTAL - 1);
  localparam logic [V_WIDTH-1:0] V_VIS      = V_WIDTH'(V_VISIBLE);

  logic [H_WIDTH-1:0] h_count;
  logic [H_WIDTH-1:0] h_next;
  logic [V_WIDTH-1:0] v_count;
  logic [V_WIDTH-1:0] v_next;
  logic [V_WIDTH-1:0] next_v_count;
  logic [V_WIDTH-1:0] next_v_load;
  logic               h_wrap;
  logic               v_wrap;
  logic               hsync_q;
  logic               vsync_q;
  logic               hsync_next;
  logic               vsync_next;
  logic               h_vis;
  logic               v_vis;
  logic               next_vis;
  logic [31:0]        h_next_ext;
  logic [31:0]        v_next_ext;

  // Sync windows are decoded from the post-increment counters so the
  // registered syncs line up with the counters they describe.
  always_comb begin
    h_wrap      = (h_count == H_LAST);
    v_wrap      = (v_count == V_LAST);
    h_next      = h_wrap ? '0 : h_count + 1'b1;
    v_next      = h_wrap ? next_v_count : v_count;
    next_v_load = v_wrap ? '0 : v_count + 1'b1;
    h_next_ext  = 32'(h_next);
    v_next_ext  = 32'(v_next);
    hsync_next  = ((h_next_ext >= 32'(HS_START)) && (h_next_ext < 32'(HS_END))) ? HSYNC_POL : ~HSYNC_POL;
    vsync_next  = ((v_next_ext >= 32'(VS_START)) && (v_next_ext < 32'(VS_END))) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge clk40) begin
    if (reset) begin
      h_count      <= '0;
      v_count      <= '0;
      next_v_count <= '0;
      hsync_q      <= ~HSYNC_POL;
      vsync_q      <= ~VSYNC_POL;
    end else if (vid.pixEn) begin
      h_count <= h_next;
      v_count <= v_next;
      hsync_q <= hsync_next;
      vsync_q <= vsync_next;
      // Loaded at the end of the visible part so it is stable through h-blank.
      if (h_count == H_VIS_LAST) begin
        next_v_count <= next_v_load;
      end
    end
  end

`ifdef FRAME_COUNTER_EN
  logic [15:0] frame_count;

  always_ff @(posedge clk40) begin
    if (reset) begin
      frame_count <= '0;
    end else if (vid.pixEn && h_wrap && v_wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end

  assign vid.frameCount = frame_count;
`endif

  assign h_vis    = (h_count < H_VIS);
  assign v_vis    = (v_count < V_VIS);
  assign next_vis = (next_v_count < V_VIS);

  assign vid.hsync           = hsync_q;
  assign vid.vsync           = vsync_q;
  assign vid.videoActive     = h_vis & v_vis;
  assign vid.hPos            = h_vis ? h_count : '0;
  assign vid.vPos            = v_vis ? v_count : '0;
  assign vid.nextFrameActive = next_vis;
  assign vid.nextVPos        = next_vis ? next_v_count : '0;
  assign vid.lineStarting    = vid.pixEn & (h_count == LS_AT);
  assign vid.lineEnding      = vid.pixEn & (h_count == LE_AT);
  assign vid.frameStart      = vid.pixEn & h_wrap & v_wrap;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed bench: default mode, small mode, inverted polarity, pixEn gating, mid-frame reset.
module tb_video_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        va;
    logic        ls;
    logic        le;
    logic        fs;
    logic        nfa;
    logic [15:0] hpos;
    logic [15:0] vpos;
    logic [15:0] nvpos;
  } vec_t;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  video_timing_gen_if #(.H_WIDTH(11), .V_WIDTH(10)) if0 ();
  video_timing_gen_if #(.H_WIDTH(4),  .V_WIDTH(3))  if1 ();
  video_timing_gen_if #(.H_WIDTH(4),  .V_WIDTH(3))  if2 ();

  video_timing_gen d0 (.clk40(clk), .reset(rst0), .vid(if0));

  video_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_WIDTH(4), .V_WIDTH(3), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPELINE_DELAY(2)
  ) d1 (.clk40(clk), .reset(rst1), .vid(if1));

  video_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_WIDTH(4), .V_WIDTH(3), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPELINE_DELAY(2)
  ) d2 (.clk40(clk), .reset(rst2), .vid(if2));

  function automatic vec_t model(input int hv, hf, hsw, hb, vv, vf, vsw, vb, pd,
                                 input bit hp, vp, input int h, v, input bit pe);
    vec_t e;
    int ht, vt, nv;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    nv = (h >= hv) ? ((v == vt - 1) ? 0 : v + 1) : v;
    e.hs    = (h >= hv + hf && h < hv + hf + hsw) ? hp : ~hp;
    e.vs    = (v >= vv + vf && v < vv + vf + vsw) ? vp : ~vp;
    e.va    = (h < hv) && (v < vv);
    e.ls    = pe && (h == ht - 1 - pd);
    e.le    = pe && (h == hv - 1 - pd);
    e.fs    = pe && (h == ht - 1) && (v == vt - 1);
    e.nfa   = (nv < vv);
    e.hpos  = (h < hv) ? 16'(h) : 16'd0;
    e.vpos  = (v < vv) ? 16'(v) : 16'd0;
    e.nvpos = (nv < vv) ? 16'(nv) : 16'd0;
    return e;
  endfunction

  function automatic vec_t mbig(input int h, v, input bit pe);
    return model(800, 40, 128, 88, 600, 1, 4, 23, 0, 1'b1, 1'b1, h, v, pe);
  endfunction

  function automatic vec_t msml(input int h, v, input bit pe, input bit pol);
    return model(8, 2, 2, 2, 4, 1, 1, 1, 2, pol, pol, h, v, pe);
  endfunction

  function automatic vec_t get0();
    vec_t a;
    a.hs = if0.hsync; a.vs = if0.vsync; a.va = if0.videoActive;
    a.ls = if0.lineStarting; a.le = if0.lineEnding; a.fs = if0.frameStart;
    a.nfa = if0.nextFrameActive;
    a.hpos = 16'(if0.hPos); a.vpos = 16'(if0.vPos); a.nvpos = 16'(if0.nextVPos);
    return a;
  endfunction

  function automatic vec_t get1();
    vec_t a;
    a.hs = if1.hsync; a.vs = if1.vsync; a.va = if1.videoActive;
    a.ls = if1.lineStarting; a.le = if1.lineEnding; a.fs = if1.frameStart;
    a.nfa = if1.nextFrameActive;
    a.hpos = 16'(if1.hPos); a.vpos = 16'(if1.vPos); a.nvpos = 16'(if1.nextVPos);
    return a;
  endfunction

  function automatic vec_t get2();
    vec_t a;
    a.hs = if2.hsync; a.vs = if2.vsync; a.va = if2.videoActive;
    a.ls = if2.lineStarting; a.le = if2.lineEnding; a.fs = if2.frameStart;
    a.nfa = if2.nextFrameActive;
    a.hpos = 16'(if2.hPos); a.vpos = 16'(if2.vPos); a.nvpos = 16'(if2.nextVPos);
    return a;
  endfunction

  function automatic string fmt(input vec_t x);
    return $sformatf("hs=%0b vs=%0b va=%0b ls=%0b le=%0b fs=%0b nfa=%0b hpos=%0d vpos=%0d nvpos=%0d",
                     x.hs, x.vs, x.va, x.ls, x.le, x.fs, x.nfa, x.hpos, x.vpos, x.nvpos);
  endfunction

  task automatic chk(input string tag, input int idx, input vec_t act, input vec_t exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s@%0d actual: %s required: %s", tag, idx, fmt(act), fmt(exp));
    end
  endtask

  task automatic chk_int(input string tag, input int act, input int exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s actual=%0d required=%0d", tag, act, exp);
    end
  endtask

  task automatic adv(inout int h, inout int v, input int ht, input int vt);
    if (h == ht - 1) begin
      h = 0;
      v = (v == vt - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  initial begin
    int  h0, v0, hs, vs, fc1, fs_cnt, hs_cnt, hs_first, ls0_cnt, ls_cnt, seek;
    bit  pe, wrap1;
    h0 = 0; v0 = 0; hs = 0; vs = 0; fc1 = 0;
    fs_cnt = 0; hs_cnt = 0; hs_first = -1; ls0_cnt = 0;
    if0.pixEn = 1'b1; if1.pixEn = 1'b1; if2.pixEn = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_d0", 0, get0(), mbig(0, 0, 1'b1));
    chk("reset_d1", 0, get1(), msml(0, 0, 1'b1, 1'b1));
    chk("reset_d2", 0, get2(), msml(0, 0, 1'b1, 1'b0));
`ifdef FRAME_COUNTER_EN
    chk_int("reset_frame_count", int'(if1.frameCount), 0);
`endif

    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    for (int k = 0; k < 3 * 1056; k++) begin
      chk("run_d0", k, get0(), mbig(h0, v0, 1'b1));
      chk("run_d1", k, get1(), msml(hs, vs, 1'b1, 1'b1));
      chk("run_d2", k, get2(), msml(hs, vs, 1'b1, 1'b0));
`ifdef FRAME_COUNTER_EN
      chk_int("run_frame_count", int'(if1.frameCount), fc1);
      if (k == 294) chk_int("frame_count_after_3", int'(if1.frameCount), 3);
`endif
      if (k == 294) chk_int("frame_start_after_3", fs_cnt, 3);
      if (v0 == 0 && if0.hsync === 1'b1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = h0;
      end
      if (if0.lineStarting === 1'b1) ls0_cnt++;
      if (if1.frameStart === 1'b1) fs_cnt++;
      wrap1 = (hs == 13) && (vs == 6);
      @(posedge clk);
      #1;
      adv(h0, v0, 1056, 628);
      adv(hs, vs, 14, 7);
      if (wrap1) fc1++;
    end
    chk_int("d0_hsync_width", hs_cnt, 128);
    chk_int("d0_hsync_start", hs_first, 840);
    chk_int("d0_line_starting_count", ls0_cnt, 3);
    chk_int("d1_frame_start_count", fs_cnt, 32);

    rst0 = 1'b1; rst2 = 1'b1;
    ls_cnt = 0;
    for (int k = 0; k < 112; k++) begin
      pe = (k % 2 == 0);
      if1.pixEn = pe;
      #1;
      chk("toggle_d1", k, get1(), msml(hs, vs, pe, 1'b1));
      if (if1.lineStarting === 1'b1) ls_cnt++;
      wrap1 = pe && (hs == 13) && (vs == 6);
      @(posedge clk);
      #1;
      if (pe) adv(hs, vs, 14, 7);
      if (wrap1) fc1++;
`ifdef FRAME_COUNTER_EN
      chk_int("toggle_frame_count", int'(if1.frameCount), fc1);
`endif
    end
    chk_int("toggle_line_starting_count", ls_cnt, 4);

    if1.pixEn = 1'b1;
    seek = 0;
    while (!(hs == 10 && vs == 5) && seek < 200) begin
      @(posedge clk);
      #1;
      adv(hs, vs, 14, 7);
      seek++;
    end
    chk_int("seek_reached", int'(hs == 10 && vs == 5), 1);
    chk("pre_reset_d1", 0, get1(), msml(hs, vs, 1'b1, 1'b1));
    chk_int("pre_reset_hsync", int'(if1.hsync), 1);
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    hs = 0; vs = 0; fc1 = 0;
    chk("mid_reset_d1", 0, get1(), msml(0, 0, 1'b1, 1'b1));
    chk_int("mid_reset_video_active", int'(if1.videoActive), 1);
    chk_int("mid_reset_vsync", int'(if1.vsync), 0);
`ifdef FRAME_COUNTER_EN
    chk_int("mid_reset_frame_count", int'(if1.frameCount), 0);
`endif
    rst1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk("after_reset_d1", k, get1(), msml(hs, vs, 1'b1, 1'b1));
      @(posedge clk);
      #1;
      adv(hs, vs, 14, 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
